// File: rtl/pc_fetch.sv
// OTTER program counter and instruction fetch stage: registers the selected
// next PC, runs a req/ack fetch, holds the returned instruction until taken.
//
// state | meaning
// IDLE  | reset state, leaves for FETCH on the first edge after reset
// FETCH | fetch_req high, fetch_addr stable, waiting for fetch_ack
// HOLD  | ir_out holds an untaken instruction, waiting for ir_take
module pc_fetch #(
  parameter int                WIDTH    = 32,
  parameter int                INSTR_W  = 32,
  parameter logic [WIDTH-1:0]  RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [WIDTH-1:0]   next_pc,
  input  logic               ir_take,
  input  logic               fetch_ack,
  input  logic [INSTR_W-1:0] fetch_data,
  output logic [WIDTH-1:0]   pc_out,
  output logic               fetch_req,
  output logic [WIDTH-1:0]   fetch_addr,
  output logic               ir_valid,
  output logic [INSTR_W-1:0] ir_out,
  output logic               misalign,
  output logic [31:0]        instr_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] pc;

  assign pc_out     = pc;
  assign fetch_addr = pc;

  // fetch_req and ir_valid are registered alongside state so they track it
  // exactly; both drop immediately on the asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      pc        <= RESET_PC;
      fetch_req <= 1'b0;
      ir_valid  <= 1'b0;
      ir_out    <= '0;
      misalign  <= 1'b0;
      instr_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          state     <= FETCH;
          fetch_req <= 1'b1;
        end
        FETCH: begin
          if (fetch_ack) begin
            ir_out    <= fetch_data;
            ir_valid  <= 1'b1;
            fetch_req <= 1'b0;
            state     <= HOLD;
          end
        end
        HOLD: begin
          if (ir_take) begin
            pc        <= {next_pc[WIDTH-1:2], 2'b00};
            if (next_pc[1:0] != 2'b00)
              misalign <= 1'b1;
            ir_valid  <= 1'b0;
            instr_cnt <= instr_cnt + 32'd1;
            fetch_req <= 1'b1;
            state     <= FETCH;
          end
        end
        default: begin
          state     <= IDLE;
          fetch_req <= 1'b0;
          ir_valid  <= 1'b0;
        end
      endcase
    end
  end

endmodule
